// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dlx_mem_pkg : shared types for the DLX data-memory responder          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dlx_mem_pkg;

  localparam int WORD_BYTES = 4;
  // Entry address is sized for the widest possible word index; narrower
  // configurations zero-extend into it.
  localparam int c_ENTRY_AW = 30;

  typedef struct packed {
    logic                  valid;
    logic [c_ENTRY_AW-1:0] addr;
    logic [31:0]           data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/dlx_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dlx_store_buffer : coalescing store FIFO with youngest-match forward  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dlx_store_buffer
  import dlx_mem_pkg::*;
#(
  parameter int AW       = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_st_en,
  input  logic [AW-1:0]             i_addr,
  input  logic [31:0]               i_st_data,
  input  logic                      i_pop,
  input  logic                      i_head_busy,
  output logic                      o_rd_hit,
  output logic [31:0]               o_rd_data,
  output logic [AW-1:0]             o_head_addr,
  output logic [31:0]               o_head_data,
  output logic                      o_coal_head,
  output logic                      o_drop,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(SB_DEPTH):0] o_count
);

  localparam int c_PW = $clog2(SB_DEPTH);
  localparam int c_CW = c_PW + 1;

  sb_entry_t             r_ent [SB_DEPTH];
  logic [c_PW-1:0]       r_head;
  logic [c_PW-1:0]       r_tail;
  logic [c_CW-1:0]       r_count;

  logic [c_ENTRY_AW-1:0] w_key;
  logic [c_PW-1:0]       w_idx;
  logic [c_PW-1:0]       w_co_idx;
  logic                  w_co_hit;
  logic                  w_coal;
  logic                  w_push;

  assign w_key = c_ENTRY_AW'(i_addr);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    o_rd_hit  = 1'b0;
    o_rd_data = '0;
    w_co_hit  = 1'b0;
    w_co_idx  = '0;
    w_idx     = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = r_head + c_PW'(k);
      if (r_ent[w_idx].valid && (r_ent[w_idx].addr == w_key)) begin
        o_rd_hit  = 1'b1;
        o_rd_data = r_ent[w_idx].data;
        if (!(i_head_busy && (w_idx == r_head))) begin
          w_co_hit = 1'b1;
          w_co_idx = w_idx;
        end
      end
    end
  end

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == c_CW'(SB_DEPTH));
  assign o_count     = r_count;
  assign w_coal      = i_st_en && w_co_hit;
  assign w_push      = i_st_en && !w_co_hit && (!o_full || i_pop);
  assign o_drop      = i_st_en && !w_co_hit && o_full && !i_pop;
  assign o_coal_head = w_coal && (w_co_idx == r_head);
  assign o_head_addr = r_ent[r_head].addr[AW-1:0];
  assign o_head_data = r_ent[r_head].data;

  // When full, tail aliases head; the push is written after the pop so the
  // freshly allocated entry keeps its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        r_ent[k].valid <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + c_PW'(1);
      end
      if (w_coal) begin
        r_ent[w_co_idx].data <= i_st_data;
      end
      if (w_push) begin
        r_ent[r_tail] <= '{valid: 1'b1, addr: w_key, data: i_st_data};
        r_tail        <= r_tail + c_PW'(1);
      end
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dlx_dmem_responder : DLX MEM-stage responder, posted stores + drain   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dlx_dmem_responder
  import dlx_mem_pkg::*;
#(
  parameter int AW       = 10,
  parameter int SB_DEPTH = 4,
  parameter int WR_LAT   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               wr_data,
  input  logic                      mem_wr_en,
  output logic [31:0]               rd_data,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_full,
  output logic                      mem_idle,
  output logic                      overflow_err,
  output logic                      addr_err
);

  localparam int c_OFS = $clog2(WORD_BYTES);
  localparam int c_LW  = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  logic [31:0]  r_mem [2**AW];
  drain_state_e r_state;
  logic [c_LW-1:0] r_lat;
  logic [AW-1:0]   r_wr_addr;
  logic [31:0]     r_wr_data;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_unused_ofs;
  logic          w_pop;
  logic          w_rd_hit;
  logic [31:0]   w_rd_fwd;
  logic [AW-1:0] w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_coal_head;
  logic          w_drop;
  logic          w_empty;

  assign w_idx        = mem_addr[AW+c_OFS-1:c_OFS];
  assign w_in_range   = (mem_addr[31:AW+c_OFS] == '0);
  assign w_unused_ofs = ^mem_addr[c_OFS-1:0];
  assign w_pop        = (r_state == ST_WRITE) && (r_lat == '0);

  dlx_store_buffer #(
    .AW       (AW),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clock),
    .rst         (reset),
    .i_st_en     (mem_wr_en && w_in_range),
    .i_addr      (w_idx),
    .i_st_data   (wr_data),
    .i_pop       (w_pop),
    .i_head_busy (r_state == ST_WRITE),
    .o_rd_hit    (w_rd_hit),
    .o_rd_data   (w_rd_fwd),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_coal_head (w_coal_head),
    .o_drop      (w_drop),
    .o_empty     (w_empty),
    .o_full      (sb_full),
    .o_count     (sb_count)
  );

  assign rd_data  = !w_in_range ? 32'h0 : (w_rd_hit ? w_rd_fwd : r_mem[w_idx]);
  assign mem_idle = w_empty && (r_state == ST_IDLE);

  // The bus has no load strobe, so any cycle presenting a bad address flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lat        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      overflow_err <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_wr_addr <= w_head_addr;
            // A store coalescing into the head on this edge must not be lost.
            r_wr_data <= w_coal_head ? wr_data : w_head_data;
            r_lat     <= c_LW'(WR_LAT - 1);
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_lat == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_lat <= r_lat - c_LW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_drop) begin
        overflow_err <= 1'b1;
      end
      if (!w_in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_pop) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

endmodule
`default_nettype wire
